mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single shared memory bus between the pipeline's instruction-fetch port (IF stage) and its data port (MEM stage). It sequences each access through a request/acknowledge handshake and generates per-stage stall signals for the pipeline registers. A bounded-starvation rule keeps fetch from starving, and a watchdog timeout prevents a silent bus from hanging the CPU.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting before fetch is forced (1..15)
- TIMEOUT, 15, maximum cycles in a bus transaction without bus_ack (2..255)

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetch data; valid only while if_ack
- if_ack  out  1  fetch completion, combinational, one cycle
- mem_rd  in  1  data read request; held until mem_ack
- mem_wr  in  1  data write request; held until mem_ack
- mem_addr  in  AW  data address
- mem_wdata  in  DW  store data
- mem_rdata  out  DW  load data; valid only while mem_ack
- mem_ack  out  1  data completion, combinational, one cycle
- bus_req  out  1  registered bus request
- bus_we  out  1  registered write enable
- bus_addr  out  AW  registered address
- bus_wdata  out  DW  registered write data
- bus_rdata  in  DW  bus read data, valid with bus_ack
- bus_ack  in  1  bus completion
- if_stall  out  1  if_req && !if_ack
- mem_stall  out  1  (mem_rd || mem_wr) && !mem_ack
- bus_err  out  1  sticky timeout flag

## Operation
- FSM states:
  - IDLE: arbitration.
  - BUS_IF: fetch owns the bus.
  - BUS_MEM: data port owns the bus.
- Arbitration in IDLE, in priority order:
  - If starve_cnt == STARVE_MAX and if_req → BUS_IF.
  - Else if mem_rd or mem_wr → BUS_MEM.
  - Else if if_req → BUS_IF.
  - Else stay in IDLE.
- Grant actions (registered on the transition edge):
  - bus_req=1.
  - bus_addr latched from the winner's address.
  - bus_we = mem_wr (BUS_MEM only; 0 for BUS_IF).
  - bus_wdata = mem_wdata.
  - mem_rd and mem_wr both high is treated as a write.
- In BUS_x while bus_ack=1:
  - The matching ack is asserted combinationally, with rdata = bus_rdata. Writes still receive mem_ack; mem_rdata is then don't-care.
  - Next state is IDLE; bus_req, bus_we and wait_cnt clear.
- Starvation counter (starve_cnt, 4 bit):
  - Increments on every BUS_MEM grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on any BUS_IF grant.
  - Clears on any arbitration cycle where if_req=0.
- Watchdog (wait_cnt, 8 bit):
  - Counts cycles in BUS_x with bus_ack=0.
  - When wait_cnt == TIMEOUT-1 and bus_ack is still 0, that cycle is the timeout cycle:
    - the owner's ack is forced to 1 with rdata = 0;
    - bus_err is set (sticky until reset);
    - next state is IDLE and bus_req drops.
  - bus_ack arriving in the timeout cycle is a normal completion: no error is raised.
- Requester rules:
  - Requesters must not change address or data while their request is pending.
  - Dropping a request before its ack is illegal. The arbiter completes the bus transaction regardless, and the ack goes to the owner.
- Reset (asynchronous, rst=0):
  - State → IDLE; both counters → 0.
  - bus_req, bus_we, bus_err → 0; bus_addr, bus_wdata → 0.
  - if_ack and mem_ack → 0 immediately, because the FSM is in IDLE.
  - Reset mid-transaction abandons it with no ack.

## Timing
- Minimum latency: request at cycle 0 (IDLE) → bus_req at cycle 1 → bus_ack earliest at cycle 1 → ack at cycle 1. This is one stall cycle.
- Latency = 1 + bus wait cycles + any queueing behind the other port.
- Back-to-back transactions: after an ack at cycle N, IDLE arbitrates at N+1 and bus_req reasserts at N+2. There is a one-cycle bus gap per transaction.
- A simultaneous if_req and data request resolve per the priority rules; the loser's stall persists through the winner's transaction.
- bus_ack while in IDLE is ignored.
- Outputs after reset: every registered output is 0; if_stall and mem_stall follow their combinational equations.

## Test plan
- Single fetch: if_req=1, if_addr=0x40, bus_ack one cycle after bus_req with bus_rdata=0x2008000A → if_ack and if_rdata=0x2008000A at cycle 2; if_stall=1 in cycles 0–1; bus_we=0.
- Conflict: if_req and mem_rd raised together at 0x100 → BUS_MEM first with bus_addr=0x100; the fetch is granted after the mem_ack; if_stall stays high throughout.
- Starvation with STARVE_MAX=4: if_req held while mem_rd re-requests continuously → exactly 4 data grants, then one BUS_IF grant, and starve_cnt returns to 0.
- Store: mem_wr=1, mem_addr=0x20, mem_wdata=0xDEADBEEF → bus_we=1, bus_wdata=0xDEADBEEF, mem_ack on bus_ack.
- Timeout with TIMEOUT=15: bus_ack never asserted → ack with rdata=0 in the 15th bus cycle, bus_err=1 and staying high, next transaction proceeds normally.
- Async reset: rst=0 mid-BUS_MEM (between edges) → bus_req=0 immediately, no mem_ack, starve_cnt=0; after release, a pending if_req is granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between the fetch and data ports,
// with bounded fetch starvation and a bus watchdog that raises a sticky error.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ack,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    output logic          if_stall,
    output logic          mem_stall,
    output logic          bus_err
);
    typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM} state_t;

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic [7:0]    wait_q, wait_d;
    logic          bus_req_q, bus_we_q, bus_err_q;
    logic [AW-1:0] bus_addr_q;
    logic [DW-1:0] bus_wdata_q;
    logic          mem_any, force_if, grant_if, grant_mem, in_bus, timeout, done;

    assign mem_any   = mem_rd || mem_wr;
    assign force_if  = starve_q == 4'(STARVE_MAX) && if_req;
    assign grant_if  = state_q == IDLE && (force_if || (!mem_any && if_req));
    assign grant_mem = state_q == IDLE && !force_if && mem_any;
    assign in_bus    = state_q != IDLE;
    // A late bus_ack in the last allowed cycle still counts as a clean completion.
    assign timeout   = in_bus && !bus_ack && wait_q == 8'(TIMEOUT - 1);
    assign done      = in_bus && (bus_ack || timeout);

    always_comb begin
        state_d  = grant_if ? BUS_IF : grant_mem ? BUS_MEM : done ? IDLE : state_q;
        starve_d = in_bus ? starve_q
                 : (!if_req || grant_if) ? 4'd0
                 : starve_q == 4'(STARVE_MAX) ? starve_q : starve_q + 4'd1;
        wait_d   = (in_bus && !done) ? wait_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            wait_q      <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
            if (grant_if || grant_mem) begin
                bus_req_q   <= 1'b1;
                bus_addr_q  <= grant_mem ? mem_addr : if_addr;
                bus_we_q    <= grant_mem && mem_wr;
                bus_wdata_q <= mem_wdata;
            end else if (done) begin
                bus_req_q <= 1'b0;
                bus_we_q  <= 1'b0;
            end
            if (timeout)
                bus_err_q <= 1'b1;
        end
    end

    assign if_ack    = state_q == BUS_IF && done;
    assign mem_ack   = state_q == BUS_MEM && done;
    assign if_rdata  = bus_ack ? bus_rdata : '0;
    assign mem_rdata = bus_ack ? bus_rdata : '0;
    assign if_stall  = if_req && !if_ack;
    assign mem_stall = mem_any && !mem_ack;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, starvation, store,
// watchdog timeout and asynchronous reset.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, bus_ack = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, bus_rdata = '0;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ack, mem_ack, bus_req, bus_we, if_stall, mem_stall, bus_err;
    int          n_chk = 0, n_fail = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .if_stall(if_stall), .mem_stall(mem_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks sample 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #3;
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_acks", {if_ack, mem_ack}, 0);
        tick();
        rst = 1'b1;
        tick();

        // single fetch
        if_req = 1; if_addr = 32'h40; #1;
        check("f_stall0", if_stall, 1);
        check("f_req0", bus_req, 0);
        tick(); #1;
        check("f_req1", bus_req, 1);
        check("f_addr1", bus_addr, 32'h40);
        check("f_we1", bus_we, 0);
        check("f_stall1", if_stall, 1);
        check("f_ack1", if_ack, 0);
        tick();
        bus_ack = 1; bus_rdata = 32'h2008000A; #1;
        check("f_ack2", if_ack, 1);
        check("f_rdata2", if_rdata, 32'h2008000A);
        check("f_stall2", if_stall, 0);
        check("f_mack2", mem_ack, 0);
        tick();
        if_req = 0; bus_ack = 0; #1;
        check("f_req_drop", bus_req, 0);

        // bus_ack while idle is ignored
        bus_ack = 1; #1;
        check("idle_acks", {if_ack, mem_ack}, 0);
        tick();
        bus_ack = 0; #1;
        check("idle_req", bus_req, 0);

        // conflict: data port wins first
        if_req = 1; if_addr = 32'h80; mem_rd = 1; mem_addr = 32'h100;
        tick(); #1;
        check("c_addr_mem", bus_addr, 32'h100);
        check("c_we", bus_we, 0);
        check("c_stalls", {if_stall, mem_stall}, 2'b11);
        bus_ack = 1; bus_rdata = 32'h55; #1;
        check("c_mack", mem_ack, 1);
        check("c_mrdata", mem_rdata, 32'h55);
        check("c_iack", if_ack, 0);
        check("c_istall", if_stall, 1);
        tick();
        mem_rd = 0; bus_ack = 0; #1;
        check("c_gap", bus_req, 0);
        check("c_istall_gap", if_stall, 1);
        tick(); #1;
        check("c_addr_if", bus_addr, 32'h80);
        check("c_req_if", bus_req, 1);
        bus_ack = 1; #1;
        check("c_iack2", if_ack, 1);
        tick();
        if_req = 0; bus_ack = 0;
        tick();

        // starvation: four data grants, then fetch is forced
        if_req = 1; if_addr = 32'h80; mem_rd = 1; mem_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check($sformatf("s_mem%0d", k), bus_addr, 32'h200);
            bus_ack = 1; #1;
            check($sformatf("s_mack%0d", k), mem_ack, 1);
            tick();
            bus_ack = 0;
        end
        tick(); #1;
        check("s_forced_if", bus_addr, 32'h80);
        check("s_mstall", mem_stall, 1);
        bus_ack = 1; #1;
        check("s_iack", if_ack, 1);
        tick();
        bus_ack = 0;
        tick(); #1;
        check("s_cnt_cleared", bus_addr, 32'h200);
        bus_ack = 1; #1;
        check("s_mack_after", mem_ack, 1);
        tick();
        if_req = 0; mem_rd = 0; bus_ack = 0;
        tick();

        // store
        mem_wr = 1; mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF;
        tick(); #1;
        check("w_we", bus_we, 1);
        check("w_wdata", bus_wdata, 32'hDEADBEEF);
        check("w_addr", bus_addr, 32'h20);
        check("w_mack_wait", mem_ack, 0);
        bus_ack = 1; #1;
        check("w_mack", mem_ack, 1);
        tick();
        mem_wr = 0; bus_ack = 0; #1;
        check("w_we_clr", bus_we, 0);

        // watchdog timeout
        if_req = 1; if_addr = 32'h44; bus_rdata = 32'hFFFF;
        tick();
        for (int i = 1; i < 15; i++) begin
            #1 check($sformatf("t_noack%0d", i), if_ack, 0);
            tick();
        end
        #1;
        check("t_ack15", if_ack, 1);
        check("t_rdata0", if_rdata, 0);
        check("t_err_pre", bus_err, 0);
        tick();
        if_req = 0; #1;
        check("t_err", bus_err, 1);
        check("t_req_drop", bus_req, 0);
        mem_rd = 1; mem_addr = 32'h300;
        tick(); #1;
        check("t_next_addr", bus_addr, 32'h300);
        bus_ack = 1; bus_rdata = 32'h1234; #1;
        check("t_next_mack", mem_ack, 1);
        check("t_next_rdata", mem_rdata, 32'h1234);
        tick();
        mem_rd = 0; bus_ack = 0; #1;
        check("t_err_sticky", bus_err, 1);

        // async reset mid BUS_MEM, then pending fetch goes first
        if_req = 1; if_addr = 32'h84; mem_rd = 1; mem_addr = 32'h400;
        tick(); #1;
        check("r_pre_addr", bus_addr, 32'h400);
        bus_ack = 1; rst = 0; #1;
        check("r_bus_req", bus_req, 0);
        check("r_mack", mem_ack, 0);
        check("r_err", bus_err, 0);
        tick();
        mem_rd = 0; bus_ack = 0;
        tick();
        rst = 1;
        tick(); #1;
        check("r_if_first", bus_addr, 32'h84);
        check("r_if_req", bus_req, 1);
        // ack arriving in the final allowed cycle is not an error
        tick();
        for (int i = 2; i < 15; i++) tick();
        bus_ack = 1; bus_rdata = 32'hABCD; #1;
        check("r_late_ack", if_ack, 1);
        check("r_late_rdata", if_rdata, 32'hABCD);
        tick();
        if_req = 0; bus_ack = 0; #1;
        check("r_late_noerr", bus_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
